alm_request_scheduler: RTL and testbench

- Shares one AXI4-Lite master port between N_REQ local requesters, e.g. several processor peripherals or DMA helpers, in front of a single AXI4-Lite slave.
- Each requester posts a single-word read or write on a simple req/ack interface.
- The scheduler arbitrates round-robin, sequences the AXI4-Lite channel handshakes, and returns read data and response status.
- One transaction is outstanding at a time.

---
 rtl/alm_request_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_alm_request_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alm_request_scheduler.sv
// rtl/alm_request_scheduler.sv - round-robin scheduler sharing one AXI4-Lite master among N_REQ requesters
module alm_request_scheduler #(
    parameter int N_REQ = 2,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic                    alm_aclk,
    input  logic                    alm_aresetn,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [N_REQ*AW-1:0]     i_addr,
    input  logic [N_REQ*DW-1:0]     i_wdata,
    input  logic [N_REQ*DW/8-1:0]   i_wstrb,
    output logic [N_REQ-1:0]        o_ack,
    output logic [DW-1:0]           o_rdata,
    output logic                    o_err,
    output logic                    o_busy,
    output logic                    alm_awvalid,
    input  logic                    alm_awready,
    output logic [AW-1:0]           alm_awaddr,
    output logic                    alm_wvalid,
    input  logic                    alm_wready,
    output logic [DW-1:0]           alm_wdata,
    output logic [DW/8-1:0]         alm_wstrb,
    input  logic                    alm_bvalid,
    output logic                    alm_bready,
    input  logic [1:0]              alm_bresp,
    output logic                    alm_arvalid,
    input  logic                    alm_arready,
    output logic [AW-1:0]           alm_araddr,
    input  logic                    alm_rvalid,
    output logic                    alm_rready,
    input  logic [DW-1:0]           alm_rdata,
    input  logic [1:0]              alm_rresp
);

    localparam int SW = DW / 8;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, gnt;
    logic             aw_done, w_done;
    logic [AW-1:0]    lat_addr;
    logic [DW-1:0]    lat_wdata;
    logic [SW-1:0]    lat_wstrb;

    logic             arb_found;
    logic [PW-1:0]    arb_idx;
    logic             arb_we;
    logic [AW-1:0]    arb_addr;
    logic [DW-1:0]    arb_wdata;
    logic [SW-1:0]    arb_wstrb;

    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;
    logic             awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic             busy_nxt, err_nxt;
    logic [DW-1:0]    rdata_nxt;
    logic [N_REQ-1:0] ack_vec, ack_nxt;
    logic [PW-1:0]    ptr_nxt;

    assign aw_hs  = alm_awvalid & alm_awready;
    assign w_hs   = alm_wvalid & alm_wready;
    assign b_hs   = alm_bvalid & alm_bready;
    assign ar_hs  = alm_arvalid & alm_arready;
    assign r_hs   = alm_rvalid & alm_rready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign alm_awaddr = lat_addr;
    assign alm_araddr = lat_addr;
    assign alm_wdata  = lat_wdata;
    assign alm_wstrb  = lat_wstrb;

    // Scan distances from the pointer downwards so the nearest requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int d = N_REQ - 1; d >= 0; d--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (i_req[k] && (((k - int'(ptr) + N_REQ) % N_REQ) == d)) begin
                    arb_found = 1'b1;
                    arb_idx   = PW'(k);
                end
            end
        end
    end

    always_comb begin
        arb_we    = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        arb_wstrb = '0;
        ack_vec   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_idx == PW'(k)) begin
                arb_we    = i_we[k];
                arb_addr  = i_addr[k*AW +: AW];
                arb_wdata = i_wdata[k*DW +: DW];
                arb_wstrb = i_wstrb[k*SW +: SW];
            end
            ack_vec[k] = (gnt == PW'(k));
        end
    end

    assign ptr_nxt = (gnt == PW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge alm_aclk or negedge alm_aresetn) begin
        if (!alm_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_found) state_nxt = arb_we ? S_WADDR : S_RADDR;
            S_WADDR: if (aw_fin && w_fin) state_nxt = S_WRESP;
            S_WRESP: if (b_hs) state_nxt = S_DONE;
            S_RADDR: if (ar_hs) state_nxt = S_RDATA;
            S_RDATA: if (r_hs) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; ack/busy/err/rdata update on entry to DONE.
    always_comb begin
        awvalid_nxt = (state == S_WADDR) && !aw_fin;
        wvalid_nxt  = (state == S_WADDR) && !w_fin;
        bready_nxt  = ((state == S_WADDR) && aw_fin && w_fin) || ((state == S_WRESP) && !b_hs);
        arvalid_nxt = (state == S_RADDR) && !ar_hs;
        rready_nxt  = ((state == S_RADDR) && ar_hs) || ((state == S_RDATA) && !r_hs);
        busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        ack_nxt     = '0;
        err_nxt     = o_err;
        rdata_nxt   = o_rdata;
        if ((state == S_WRESP) && b_hs) begin
            ack_nxt = ack_vec;
            err_nxt = (alm_bresp != 2'b00);
        end
        if ((state == S_RDATA) && r_hs) begin
            ack_nxt   = ack_vec;
            err_nxt   = (alm_rresp != 2'b00);
            rdata_nxt = alm_rdata;
        end
    end

    always_ff @(posedge alm_aclk or negedge alm_aresetn) begin
        if (!alm_aresetn) begin
            ptr         <= '0;
            gnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            alm_awvalid <= 1'b0;
            alm_wvalid  <= 1'b0;
            alm_bready  <= 1'b0;
            alm_arvalid <= 1'b0;
            alm_rready  <= 1'b0;
            o_ack       <= '0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= '0;
        end else begin
            aw_done     <= (state == S_WADDR) && aw_fin;
            w_done      <= (state == S_WADDR) && w_fin;
            alm_awvalid <= awvalid_nxt;
            alm_wvalid  <= wvalid_nxt;
            alm_bready  <= bready_nxt;
            alm_arvalid <= arvalid_nxt;
            alm_rready  <= rready_nxt;
            o_ack       <= ack_nxt;
            o_busy      <= busy_nxt;
            o_err       <= err_nxt;
            o_rdata     <= rdata_nxt;
            if ((state == S_IDLE) && arb_found) begin
                gnt       <= arb_idx;
                lat_addr  <= arb_addr;
                lat_wdata <= arb_wdata;
                lat_wstrb <= arb_wstrb;
            end
            if (state == S_DONE) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alm_request_scheduler.sv
// tb/tb_alm_request_scheduler.sv - scoreboard bench for alm_request_scheduler with AXI4-Lite memory slave
module tb_alm_request_scheduler;

    localparam int NR = 3;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    i_req = '0, i_we = '0;
    logic [NR*AW-1:0] i_addr = '0;
    logic [NR*DW-1:0] i_wdata = '0;
    logic [NR*SW-1:0] i_wstrb = '0;
    logic [NR-1:0]    o_ack;
    logic [DW-1:0]    o_rdata;
    logic             o_err, o_busy;
    logic             alm_awvalid, alm_awready, alm_wvalid, alm_wready;
    logic             alm_bvalid, alm_bready, alm_arvalid, alm_arready, alm_rvalid, alm_rready;
    logic [AW-1:0]    alm_awaddr, alm_araddr;
    logic [DW-1:0]    alm_wdata, alm_rdata;
    logic [SW-1:0]    alm_wstrb;
    logic [1:0]       alm_bresp, alm_rresp;

    alm_request_scheduler #(.N_REQ(NR), .AW(AW), .DW(DW)) dut (
        .alm_aclk(clk), .alm_aresetn(rst_n),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err), .o_busy(o_busy),
        .alm_awvalid(alm_awvalid), .alm_awready(alm_awready), .alm_awaddr(alm_awaddr),
        .alm_wvalid(alm_wvalid), .alm_wready(alm_wready), .alm_wdata(alm_wdata), .alm_wstrb(alm_wstrb),
        .alm_bvalid(alm_bvalid), .alm_bready(alm_bready), .alm_bresp(alm_bresp),
        .alm_arvalid(alm_arvalid), .alm_arready(alm_arready), .alm_araddr(alm_araddr),
        .alm_rvalid(alm_rvalid), .alm_rready(alm_rready), .alm_rdata(alm_rdata), .alm_rresp(alm_rresp)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } op_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    op_t           ops[NR][$];
    exp_t          exp_q[$];
    int            n_vec = 0, n_err = 0;
    logic [DW-1:0] mem_s[32], mem_m[32];
    logic [DW-1:0] last_rd;
    int            m_ptr;
    bit            rand_mode = 0, stall_r = 0;
    int            fix_aw = 0, fix_w = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic is_err(input logic [AW-1:0] a);
        return a[6:2] >= 5'd28;
    endfunction

    function automatic logic [DW-1:0] err_pat(input logic [AW-1:0] a);
        return 32'hBAD0_0000 | 32'(a[6:2]);
    endfunction

    function automatic logic [63:0] outs();
        return {22'd0, alm_awvalid, alm_wvalid, alm_bready, alm_arvalid, alm_rready,
                o_ack, o_busy, o_err, o_rdata};
    endfunction

    // Reference model: slave memory semantics applied in predicted completion order.
    task automatic model_op(input int k, input op_t op, output exp_t e);
        e.idx = k;
        e.err = is_err(op.addr);
        if (op.we) begin
            if (!e.err)
                for (int b = 0; b < SW; b++)
                    if (op.wstrb[b]) mem_m[op.addr[6:2]][8*b +: 8] = op.wdata[8*b +: 8];
            e.rdata = last_rd;
        end else begin
            last_rd = e.err ? err_pat(op.addr) : mem_m[op.addr[6:2]];
            e.rdata = last_rd;
        end
    endtask

    task automatic load_op(input int k, input op_t op);
        i_we[k]              = op.we;
        i_addr[k*AW +: AW]   = op.addr;
        i_wdata[k*DW +: DW]  = op.wdata;
        i_wstrb[k*SW +: SW]  = op.wstrb;
    endtask

    task automatic run_round();
        int rem[NR];
        int cur[NR];
        int total = 0, remaining, c = 0, p;
        for (int k = 0; k < NR; k++) begin
            rem[k] = ops[k].size();
            cur[k] = 0;
            total += rem[k];
        end
        p = m_ptr;
        for (int t = 0; t < total; t++) begin
            bit f = 0;
            for (int i = 0; i < NR; i++) begin
                int k = (p + i) % NR;
                if (!f && rem[k] > 0) begin
                    exp_t e;
                    f = 1;
                    model_op(k, ops[k][cur[k]], e);
                    exp_q.push_back(e);
                    cur[k]++;
                    rem[k]--;
                    p = (k + 1) % NR;
                end
            end
        end
        m_ptr = p;
        for (int k = 0; k < NR; k++) begin
            cur[k] = 0;
            if (ops[k].size() > 0) begin
                load_op(k, ops[k][0]);
                i_req[k] = 1'b1;
            end
        end
        remaining = total;
        while (remaining > 0 && c < 60 * total) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("lat0", {alm_awvalid, alm_arvalid}, 0);
            if (c == 2) chk("lat1", {alm_awvalid | alm_arvalid, o_busy}, 2'b11);
            for (int k = 0; k < NR; k++) begin
                if (o_ack[k]) begin
                    cur[k]++;
                    remaining--;
                    if (cur[k] < ops[k].size()) load_op(k, ops[k][cur[k]]);
                    else i_req[k] = 1'b0;
                end
            end
        end
        if (remaining > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d acks missing", remaining);
            i_req = '0;
            exp_q.delete();
        end
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
        for (int k = 0; k < NR; k++) ops[k].delete();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && |o_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_ack: got %b want none", o_ack);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_idx", o_ack, NR'(1) << e.idx);
                chk("rdata", o_rdata, e.rdata);
                chk("err", o_err, e.err);
            end
        end
    end

    // AXI4-Lite memory slave; handshakes recorded at negedge complete on the next posedge.
    bit            aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got, pv_aw, pv_w, pv_ar;
    logic [AW-1:0] pv_awaddr, pv_araddr, aw_a, ar_a;
    logic [DW-1:0] pv_wdata, w_d;
    logic [SW-1:0] pv_wstrb, w_s;
    int            aw_wait, w_wait, ar_wait, b_wait, r_wait, aw_lat, w_lat, ar_lat, b_lat, r_lat;

    function automatic int pick(input int f);
        return rand_mode ? int'($urandom_range(0, 3)) : f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            alm_awready = 0; alm_wready = 0; alm_arready = 0; alm_bvalid = 0; alm_rvalid = 0;
            alm_bresp = 0; alm_rresp = 0; alm_rdata = 0;
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            aw_got = 0; w_got = 0; ar_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
        end else begin
            if (pv_aw && !aw_pend) chk("aw_hold", {alm_awvalid, alm_awaddr}, {1'b1, pv_awaddr});
            if (pv_w && !w_pend) chk("w_hold", {alm_wvalid, alm_wstrb, alm_wdata}, {1'b1, pv_wstrb, pv_wdata});
            if (pv_ar && !ar_pend) chk("ar_hold", {alm_arvalid, alm_araddr}, {1'b1, pv_araddr});
            if (aw_pend) begin aw_got = 1; aw_a = pv_awaddr; end
            if (w_pend) begin w_got = 1; w_d = pv_wdata; w_s = pv_wstrb; end
            if (b_pend) begin alm_bvalid = 0; aw_got = 0; w_got = 0; end
            if (ar_pend) begin ar_got = 1; ar_a = pv_araddr; end
            if (r_pend) alm_rvalid = 0;
            if (alm_bready) chk("b_order", {aw_got, w_got}, 2'b11);
            if (aw_got && w_got && !alm_bvalid) begin
                if (b_wait >= b_lat) begin
                    if (!is_err(aw_a))
                        for (int b = 0; b < SW; b++)
                            if (w_s[b]) mem_s[aw_a[6:2]][8*b +: 8] = w_d[8*b +: 8];
                    alm_bvalid = 1;
                    alm_bresp  = is_err(aw_a) ? 2'b10 : 2'b00;
                    b_wait = 0;
                    b_lat  = pick(0);
                end else b_wait++;
            end
            if (ar_got && !alm_rvalid && !stall_r) begin
                if (r_wait >= r_lat) begin
                    alm_rvalid = 1;
                    alm_rdata  = is_err(ar_a) ? err_pat(ar_a) : mem_s[ar_a[6:2]];
                    alm_rresp  = is_err(ar_a) ? 2'b10 : 2'b00;
                    ar_got = 0;
                    r_wait = 0;
                    r_lat  = pick(0);
                end else r_wait++;
            end
            alm_awready = alm_awvalid && (aw_wait >= (rand_mode ? aw_lat : fix_aw));
            alm_wready  = alm_wvalid && (w_wait >= (rand_mode ? w_lat : fix_w));
            alm_arready = alm_arvalid && (ar_wait >= (rand_mode ? ar_lat : 0));
            if (alm_awvalid) begin
                if (alm_awready) begin aw_wait = 0; aw_lat = pick(0); end else aw_wait++;
            end
            if (alm_wvalid) begin
                if (alm_wready) begin w_wait = 0; w_lat = pick(0); end else w_wait++;
            end
            if (alm_arvalid) begin
                if (alm_arready) begin ar_wait = 0; ar_lat = pick(0); end else ar_wait++;
            end
            aw_pend = alm_awvalid && alm_awready;
            w_pend  = alm_wvalid && alm_wready;
            ar_pend = alm_arvalid && alm_arready;
            b_pend  = alm_bvalid && alm_bready;
            r_pend  = alm_rvalid && alm_rready;
            pv_aw = alm_awvalid; pv_awaddr = alm_awaddr;
            pv_w  = alm_wvalid;  pv_wdata  = alm_wdata; pv_wstrb = alm_wstrb;
            pv_ar = alm_arvalid; pv_araddr = alm_araddr;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_s[i] = 32'(i) * 32'h0101_0101;
            mem_m[i] = 32'(i) * 32'h0101_0101;
        end
        m_ptr   = 0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        chk("reset", outs(), 0);
        rst_n = 1'b1;

        ops[0].push_back('{1'b1, 7'h10, 32'h1234_5678, 4'hF});
        run_round();
        chk("mem_wr", mem_s[4], 32'h1234_5678);
        ops[1].push_back('{1'b0, 7'h10, 32'h0, 4'h0});
        run_round();

        fix_w = 3;
        ops[0].push_back('{1'b1, 7'h10, 32'hAABB_CCDD, 4'b0011});
        run_round();
        fix_w = 0;
        chk("mem_strb", mem_s[4], 32'h1234_CCDD);
        ops[1].push_back('{1'b0, 7'h10, 32'h0, 4'h0});
        run_round();

        for (int j = 0; j < 2; j++) begin
            ops[0].push_back('{1'b0, 7'h08, 32'h0, 4'h0});
            ops[1].push_back('{1'b0, 7'h0C, 32'h0, 4'h0});
        end
        run_round();

        ops[2].push_back('{1'b1, 7'h70, 32'hFFFF_FFFF, 4'hF});
        run_round();
        ops[2].push_back('{1'b0, 7'h10, 32'h0, 4'h0});
        run_round();

        rand_mode = 1;
        for (int r = 0; r < 40; r++) begin
            int tot = 0;
            for (int k = 0; k < NR; k++) begin
                int n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) begin
                    op_t o;
                    o.we    = 1'($urandom_range(0, 1));
                    o.addr  = {5'($urandom_range(0, 31)), 2'b00};
                    o.wdata = $urandom;
                    o.wstrb = 4'($urandom_range(1, 15));
                    ops[k].push_back(o);
                end
                tot += n;
            end
            if (tot == 0) ops[0].push_back('{1'b0, 7'h04, 32'h0, 4'h0});
            run_round();
        end
        rand_mode = 0;

        stall_r = 1;
        load_op(0, '{1'b0, 7'h14, 32'h0, 4'h0});
        i_req[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (alm_rready) break;
        end
        chk("reach_rdata", alm_rready, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 0);
        i_req   = '0;
        stall_r = 0;
        repeat (3) @(negedge clk);
        chk("rst_hold", outs(), 0);
        rst_n   = 1'b1;
        m_ptr   = 0;
        last_rd = '0;
        ops[1].push_back('{1'b0, 7'h10, 32'h0, 4'h0});
        ops[0].push_back('{1'b1, 7'h18, 32'h0BAD_F00D, 4'hF});
        run_round();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
